aes_sub_bytes: RTL and testbench

//   AES-128 SubBytes stage: applies the FIPS-197 S-box independently to each of the
//   16 bytes of a 128-bit state. Registered, single-cycle-latency block in the AES

---
 rtl/aes_pkg.sv | 87 ++++++++
 rtl/aes_sbox.sv | 18 +
 rtl/aes_sub_bytes.sv | 47 ++++
 tb/tb_aes_sub_bytes.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and the FIPS-197 forward/inverse S-box lookup tables.
package aes_pkg;
  typedef logic [7:0]   aes_byte_t;
  typedef logic [127:0] aes_state_t;

  localparam int AES_NUM_BYTES = 16;

  function automatic aes_byte_t sbox_fwd(input aes_byte_t b);
    aes_byte_t r;
    r = 8'h00;
    case (b)
      8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5;
      8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
      8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0;
      8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
      8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc;
      8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
      8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a;
      8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
      8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0;
      8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
      8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b;
      8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
      8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85;
      8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
      8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5;
      8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
      8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17;
      8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
      8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88;
      8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
      8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c;
      8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
      8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9;
      8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
      8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6;
      8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
      8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e;
      8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
      8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94;
      8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
      8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68;
      8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
    endcase
    return r;
  endfunction

  function automatic aes_byte_t sbox_inv(input aes_byte_t b);
    aes_byte_t r;
    r = 8'h00;
    case (b)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Single-byte combinational S-box lane; AES_SUBBYTES_INV_EN adds the i_inv select.
module aes_sbox
  import aes_pkg::*;
(
`ifdef AES_SUBBYTES_INV_EN
  input  logic      i_inv,
`endif
  input  aes_byte_t i_byte,
  output aes_byte_t o_byte
);

`ifdef AES_SUBBYTES_INV_EN
  assign o_byte = i_inv ? sbox_inv(i_byte) : sbox_fwd(i_byte);
`else
  assign o_byte = sbox_fwd(i_byte);
`endif

endmodule

// File: rtl/aes_sub_bytes.sv
// Registered AES SubBytes stage, one-cycle latency, one state per cycle.
// Build option AES_SUBBYTES_INV_EN adds the inv port selecting the inverse S-box.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  aes_state_t a,
`ifdef AES_SUBBYTES_INV_EN
  input  logic       inv,
`endif
  output logic       out_valid,
  output aes_state_t res
);

  aes_state_t w_sub;
  aes_state_t r_res;
  logic       r_valid;

  for (genvar i = 0; i < AES_NUM_BYTES; i++) begin : g_lane
    aes_sbox u_sbox (
`ifdef AES_SUBBYTES_INV_EN
      .i_inv  (inv),
`endif
      .i_byte (a[8*i +: 8]),
      .o_byte (w_sub[8*i +: 8])
    );
  end

  // The result register only loads on a valid beat, so res holds across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_res <= w_sub;
      end
    end
  end

  assign out_valid = r_valid;
  assign res       = r_res;

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Self-checking bench for aes_sub_bytes: FIPS vectors, exhaustive lanes, reset and random streaming.
// The reference S-box is derived from GF(2^8) inversion plus the affine transform.
module tb_aes_sub_bytes;
  import aes_pkg::*;

`ifdef AES_SUBBYTES_INV_EN
  localparam bit INV_BUILD = 1'b1;
`else
  localparam bit INV_BUILD = 1'b0;
`endif

  typedef struct {
    string      name;
    aes_state_t a;
    logic       inv;
    aes_state_t exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  aes_state_t a;
  logic       inv;
  logic       out_valid;
  aes_state_t res;

  int checks;
  int failures;

  logic [7:0] fwdTab [256];
  logic [7:0] invTab [256];
  logic       mdlValid;
  aes_state_t mdlRes;
  vec_t       vecs[$];

  aes_sub_bytes dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
`ifdef AES_SUBBYTES_INV_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .res       (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gfMul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    logic [7:0] yy;
    p = 8'h00;
    xx = x;
    yy = y;
    for (int k = 0; k < 8; k++) begin
      if (yy[0]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
      yy = yy >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S(x) = affine(x^254) in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] refSbox(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h01;
    for (int k = 0; k < 254; k++) b = gfMul(b, x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic aes_state_t refSubBytes(input aes_state_t s, input logic useInv);
    aes_state_t r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = useInv ? invTab[s[8*k +: 8]] : fwdTab[s[8*k +: 8]];
    end
    return r;
  endfunction

  function automatic aes_state_t randState();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one beat just after a negedge and advances the model to the next posedge.
  task automatic applyStimulus(input logic r, input logic v, input aes_state_t s, input logic iv);
    rst      = r;
    in_valid = v;
    a        = s;
    inv      = iv;
    if (r) begin
      mdlValid = 1'b0;
      mdlRes   = '0;
    end else begin
      mdlValid = v;
      if (v) mdlRes = refSubBytes(s, inv & INV_BUILD);
    end
  endtask

  task automatic checkOutput(input string name, input logic expValid, input aes_state_t expRes);
    checks++;
    if (out_valid !== expValid) begin
      failures++;
      $display("[TB] FAIL %s out_valid: got %0b expected %0b", name, out_valid, expValid);
    end
    checks++;
    if (res !== expRes) begin
      failures++;
      $display("[TB] FAIL %s res: got %032h expected %032h", name, res, expRes);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    inv      = 1'b0;
    mdlValid = 1'b0;
    mdlRes   = '0;

    for (int v = 0; v < 256; v++) fwdTab[v] = refSbox(8'(v));
    for (int v = 0; v < 256; v++) invTab[fwdTab[v]] = 8'(v);

    vecs.push_back('{"fips197", 128'h19a09ae93df4c6f8e3e28d48be2b2a08, 1'b0,
                     128'hd4e0b81e27bfb44111985d52aef1e530});
    vecs.push_back('{"all_zero", 128'h0, 1'b0, {16{8'h63}}});
    vecs.push_back('{"all_ff", {16{8'hff}}, 1'b0, {16{8'h16}}});
    vecs.push_back('{"lane_order", 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                     128'h637c777bf26b6fc53001672bfed7ab76});
    vecs.push_back('{"s53", {16{8'h53}}, 1'b0, {16{8'hed}}});
`ifdef AES_SUBBYTES_INV_EN
    vecs.push_back('{"fips197_inv", 128'hd4e0b81e27bfb44111985d52aef1e530, 1'b1,
                     128'h19a09ae93df4c6f8e3e28d48be2b2a08});
    vecs.push_back('{"inv_63", {16{8'h63}}, 1'b1, 128'h0});
`endif

    @(negedge clk);
    checkOutput("reset_state", 1'b0, 128'h0);

    // Load a live result, then reset with in_valid high: reset must win.
    applyStimulus(1'b0, 1'b1, 128'h19a09ae93df4c6f8e3e28d48be2b2a08, 1'b0);
    @(negedge clk);
    checkOutput("pre_reset_load", 1'b1, 128'hd4e0b81e27bfb44111985d52aef1e530);
    applyStimulus(1'b1, 1'b1, randState(), 1'b0);
    @(negedge clk);
    checkOutput("reset_wins", 1'b0, 128'h0);
    applyStimulus(1'b0, 1'b0, randState(), 1'b0);
    @(negedge clk);
    checkOutput("idle_after_reset", 1'b0, 128'h0);

    foreach (vecs[i]) begin
      applyStimulus(1'b0, 1'b1, vecs[i].a, vecs[i].inv);
      @(negedge clk);
      checkOutput(vecs[i].name, 1'b1, vecs[i].exp);
      applyStimulus(1'b0, 1'b0, randState(), 1'b0);
      @(negedge clk);
      checkOutput({vecs[i].name, "_hold"}, 1'b0, vecs[i].exp);
    end

    // Three back-to-back states, then a drop of out_valid.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, randState(), 1'b0);
      @(negedge clk);
      checkOutput($sformatf("stream_%0d", k), mdlValid, mdlRes);
    end
    applyStimulus(1'b0, 1'b0, randState(), 1'b0);
    @(negedge clk);
    checkOutput("stream_drop", mdlValid, mdlRes);

    for (int v = 0; v < 256; v++) begin
      applyStimulus(1'b0, 1'b1, {16{8'(v)}}, v[0]);
      @(negedge clk);
      checkOutput($sformatf("exhaustive_%02h", v), mdlValid, mdlRes);
    end

    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, randState(),
                    1'($urandom_range(0, 1)));
      @(negedge clk);
      checkOutput($sformatf("random_%0d", k), mdlValid, mdlRes);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
